// File: rtl/swipt_frame_transmitter.sv
// ============================================================================
// Module      : swipt_frame_transmitter
// Description : Serialises one SWIPT frame (start, mode, type, data, ones-count
//               checksum) MSB first onto dout, followed by a low guard gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swipt_frame_transmitter #(
   parameter int BIT_PERIOD = 200000,
   parameter int DATA_W     = 8,
   parameter int GAP_BITS   = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              swiptAlive,
   input  logic [1:0]        prog,
   input  logic              sendReq,
   input  logic [1:0]        mode,
   input  logic [1:0]        frameType,
   input  logic [DATA_W-1:0] dataOut,
   output logic              dout,
   output logic              busy,
   output logic              dataSent,
   output logic              txAbort
);

   localparam int c_HDR_W   = 1 + 2 + 2 + DATA_W;
   localparam int c_FRAME_W = c_HDR_W + 8;
   localparam int c_CW      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int c_IDX_MAX = (c_FRAME_W > GAP_BITS) ? c_FRAME_W : GAP_BITS;
   localparam int c_IW      = $clog2(c_IDX_MAX + 1);

   localparam logic [c_CW-1:0] c_PER_LAST  = c_CW'(BIT_PERIOD - 1);
   localparam logic [c_IW-1:0] c_BIT_LAST  = c_IW'(c_FRAME_W - 1);
   localparam logic [c_IW-1:0] c_GAP_LAST  = c_IW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                 r_state,    w_state_nxt;
   logic [c_FRAME_W-1:0]   r_shift,    w_shift_nxt;
   logic [c_CW-1:0]        r_cnt,      w_cnt_nxt;
   logic [c_IW-1:0]        r_idx,      w_idx_nxt;
   logic                   r_dout,     w_dout_nxt;
   logic                   r_busy,     w_busy_nxt;
   logic                   r_dataSent, w_sent_nxt;
   logic                   r_txAbort,  w_abort_nxt;

   logic                   w_enable;
   logic [c_HDR_W-1:0]     w_hdr;
   logic [7:0]             w_chk;
   logic [c_FRAME_W-1:0]   w_frame;

   // Checksum counts ones over the header including the start bit, the same
   // running sum the receiver accumulates.
   always_comb begin
      w_enable = swiptAlive && (prog == 2'b11);
      w_hdr    = {1'b1, mode, frameType, dataOut};
      w_chk    = '0;
      for (int i = 0; i < c_HDR_W; i++) begin
         w_chk = w_chk + {7'd0, w_hdr[i]};
      end
      w_frame  = {w_hdr, w_chk};
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_dout_nxt  = 1'b0;
      w_busy_nxt  = r_busy;
      w_sent_nxt  = 1'b0;
      w_abort_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            // The dataSent cycle is still owned by the finished frame, so a
            // held request is taken one cycle later.
            if (w_enable && sendReq && !r_dataSent) begin
               w_state_nxt = S_SEND;
               w_shift_nxt = w_frame;
               w_cnt_nxt   = c_PER_LAST;
               w_idx_nxt   = c_BIT_LAST;
               w_dout_nxt  = w_frame[c_FRAME_W-1];
               w_busy_nxt  = 1'b1;
            end
         end

         S_SEND: begin
            if (!w_enable) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_abort_nxt = 1'b1;
            end else if (r_cnt != '0) begin
               w_cnt_nxt  = r_cnt - c_CW'(1);
               w_dout_nxt = r_shift[c_FRAME_W-1];
            end else if (r_idx != '0) begin
               w_shift_nxt = {r_shift[c_FRAME_W-2:0], 1'b0};
               w_dout_nxt  = r_shift[c_FRAME_W-2];
               w_idx_nxt   = r_idx - c_IW'(1);
               w_cnt_nxt   = c_PER_LAST;
            end else if (GAP_BITS == 0) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_sent_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = c_PER_LAST;
               w_idx_nxt   = c_GAP_LAST;
            end
         end

         S_GAP: begin
            if (!w_enable) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_abort_nxt = 1'b1;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - c_CW'(1);
            end else if (r_idx != '0) begin
               w_idx_nxt = r_idx - c_IW'(1);
               w_cnt_nxt = c_PER_LAST;
            end else begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_sent_nxt  = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_dout     <= 1'b0;
         r_busy     <= 1'b0;
         r_dataSent <= 1'b0;
         r_txAbort  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_dout     <= w_dout_nxt;
         r_busy     <= w_busy_nxt;
         r_dataSent <= w_sent_nxt;
         r_txAbort  <= w_abort_nxt;
      end
   end

   assign dout     = r_dout;
   assign busy     = r_busy;
   assign dataSent = r_dataSent;
   assign txAbort  = r_txAbort;

endmodule

`default_nettype wire
